// File: rtl/dmem_resp.sv
// Single-outstanding data-memory responder: accepts one request, answers after
// LATENCY cycles with read data or an error, and commits strobed stores on the response edge.
module dmem_resp #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dmem_valid,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_wen,
    output logic        dmem_ready,
    output logic        dmem_resp_valid,
    output logic [31:0] dmem_rdata,
    output logic        dmem_err
);

    localparam int unsigned AW       = $clog2(DEPTH_WORDS);
    localparam logic [2:0]  CNT_LOAD = (LATENCY > 32'd1) ? 3'(LATENCY - 32'd2) : 3'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state_r;
    logic [2:0]    cnt_r;
    logic [31:0]   addr_r;
    logic [31:0]   wdata_r;
    logic [3:0]    wen_r;
    logic [31:0]   mem [DEPTH_WORDS];

    logic [31:0]   cur_addr_s;
    logic [3:0]    cur_wen_s;
    logic [29:0]   word_s;
    logic [AW-1:0] idx_s;
    logic          oor_s;
    logic          err_s;
    logic [31:0]   resp_rdata_s;
    logic [31:0]   wr_lanes_s;

    function automatic logic wen_legal(input logic [3:0] wen);
        logic ok;
        case (wen)
            4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: ok = 1'b1;
            default:                   ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Byte and half stores are replicated across lanes; the strobes pick the live ones.
    function automatic logic [31:0] lane_data(input logic [3:0] wen, input logic [31:0] wdata);
        logic [31:0] d;
        case (wen)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: d = {4{wdata[7:0]}};
            4'b0011, 4'b1100:                   d = {2{wdata[15:0]}};
            4'b1111:                            d = wdata;
            default:                            d = 32'h0000_0000;
        endcase
        return d;
    endfunction

    // Request decode: straight from the inputs while idle (LATENCY=1 needs it), else from the capture.
    always_comb begin
        if (state_r == IDLE) begin
            cur_addr_s = dmem_addr;
            cur_wen_s  = dmem_wen;
        end else begin
            cur_addr_s = addr_r;
            cur_wen_s  = wen_r;
        end
        word_s       = cur_addr_s[31:2] - BASE_ADDR[31:2];
        idx_s        = word_s[AW-1:0];
        oor_s        = (cur_addr_s < BASE_ADDR) || ({2'b00, word_s} >= 32'(DEPTH_WORDS));
        err_s        = oor_s || !wen_legal(cur_wen_s);
        resp_rdata_s = (err_s || (cur_wen_s != 4'b0000)) ? 32'h0000_0000 : mem[idx_s];
        wr_lanes_s   = lane_data(wen_r, wdata_r);
    end

    // Request FSM with registered handshake and response outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r         <= IDLE;
            cnt_r           <= 3'd0;
            addr_r          <= 32'h0000_0000;
            wdata_r         <= 32'h0000_0000;
            wen_r           <= 4'b0000;
            dmem_ready      <= 1'b0;
            dmem_resp_valid <= 1'b0;
            dmem_err        <= 1'b0;
            dmem_rdata      <= 32'h0000_0000;
        end else begin
            case (state_r)
                IDLE: begin
                    dmem_resp_valid <= 1'b0;
                    dmem_err        <= 1'b0;
                    dmem_rdata      <= 32'h0000_0000;
                    if (dmem_valid && dmem_ready) begin
                        addr_r     <= dmem_addr;
                        wdata_r    <= dmem_wdata;
                        wen_r      <= dmem_wen;
                        dmem_ready <= 1'b0;
                        if (LATENCY == 32'd1) begin
                            state_r         <= RESP;
                            dmem_resp_valid <= 1'b1;
                            dmem_err        <= err_s;
                            dmem_rdata      <= resp_rdata_s;
                        end else begin
                            state_r <= WAIT;
                            cnt_r   <= CNT_LOAD;
                        end
                    end else begin
                        dmem_ready <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt_r == 3'd0) begin
                        state_r         <= RESP;
                        dmem_resp_valid <= 1'b1;
                        dmem_err        <= err_s;
                        dmem_rdata      <= resp_rdata_s;
                    end else begin
                        cnt_r <= cnt_r - 3'd1;
                    end
                end
                RESP: begin
                    state_r         <= IDLE;
                    dmem_ready      <= 1'b1;
                    dmem_resp_valid <= 1'b0;
                    dmem_err        <= 1'b0;
                    dmem_rdata      <= 32'h0000_0000;
                end
                default: begin
                    state_r         <= IDLE;
                    cnt_r           <= 3'd0;
                    dmem_ready      <= 1'b0;
                    dmem_resp_valid <= 1'b0;
                    dmem_err        <= 1'b0;
                    dmem_rdata      <= 32'h0000_0000;
                end
            endcase
        end
    end

    // Store commit on the edge leaving RESP; storage itself is never cleared.
    always_ff @(posedge clk) begin
        if (rst && (state_r == RESP) && !dmem_err && (wen_r != 4'b0000)) begin
            for (int i = 0; i < 4; i++) begin
                if (wen_r[i]) begin
                    mem[idx_s][8*i +: 8] <= wr_lanes_s[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_resp.sv
// Randomized bench for dmem_resp: transaction-level memory model plus per-cycle output compare.
module tb_dmem_resp;

    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int unsigned LAT   = 2;

    logic        clk;
    logic        rst;
    logic        dmem_valid;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wen;
    logic        dmem_ready;
    logic        dmem_resp_valid;
    logic [31:0] dmem_rdata;
    logic        dmem_err;

    dmem_resp #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .dmem_valid(dmem_valid), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wen(dmem_wen), .dmem_ready(dmem_ready),
        .dmem_resp_valid(dmem_resp_valid), .dmem_rdata(dmem_rdata), .dmem_err(dmem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          acc_cnt = 0;
    int          acc_cyc = 0;
    int          resp_cyc = 0;
    bit          pending = 1'b0;
    bit          ready_m = 1'b0;
    bit          chk_en = 1'b0;
    bit          p_err = 1'b0;
    logic [31:0] p_addr = 32'h0;
    logic [31:0] p_wdata = 32'h0;
    logic [3:0]  p_wen = 4'h0;
    logic [31:0] mmem [DEPTH];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s timed out (cycle %0d)", nm, cyc);
    endtask

    function automatic bit model_err(input logic [31:0] a, input logic [3:0] w);
        bit oor;
        bit bad;
        oor = (a < BASE) || (((a - BASE) >> 2) >= DEPTH);
        bad = !(w inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111});
        return oor || bad;
    endfunction

    function automatic int model_idx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    function automatic logic [31:0] model_merge(input logic [31:0] old, input logic [31:0] d,
                                                input logic [3:0] w);
        logic [31:0] r;
        int n;
        r = old;
        n = $countones(w);
        for (int i = 0; i < 4; i++) begin
            if (w[i]) begin
                if (n == 1)      r[8*i +: 8] = d[7:0];
                else if (n == 2) r[8*i +: 8] = d[8*(i%2) +: 8];
                else             r[8*i +: 8] = d[8*i +: 8];
            end
        end
        return r;
    endfunction

    // Transaction model: one request in flight, answered LAT cycles after acceptance.
    always @(posedge clk) begin
        if (!rst) begin
            pending <= 1'b0;
            ready_m <= 1'b0;
        end else if (pending && (cyc == resp_cyc)) begin
            if (!p_err) mmem[model_idx(p_addr)] <= model_merge(mmem[model_idx(p_addr)], p_wdata, p_wen);
            pending <= 1'b0;
            ready_m <= 1'b1;
        end else if (ready_m && dmem_valid) begin
            pending  <= 1'b1;
            ready_m  <= 1'b0;
            p_addr   <= dmem_addr;
            p_wdata  <= dmem_wdata;
            p_wen    <= dmem_wen;
            p_err    <= model_err(dmem_addr, dmem_wen);
            acc_cyc  <= cyc;
            resp_cyc <= cyc + LAT;
            acc_cnt  <= acc_cnt + 1;
        end else if (!pending) begin
            ready_m <= 1'b1;
        end
        cyc <= cyc + 1;
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        bit exp_rv;
        if (chk_en) begin
            exp_rv = pending && (cyc == resp_cyc);
            chk("ready", dmem_ready, ready_m);
            chk("resp_valid", dmem_resp_valid, exp_rv);
            chk("err", dmem_err, exp_rv && p_err);
            if (!exp_rv || p_err)      chk("rdata_zero", dmem_rdata, 32'h0);
            else if (p_wen == 4'b0000) chk("rdata", dmem_rdata, mmem[model_idx(p_addr)]);
        end
    end

    task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w,
                          output logic [31:0] rd, output logic er, output int lat);
        int n0;
        int k;
        rd  = 32'hFFFF_FFFF;
        er  = 1'b1;
        lat = -1;
        @(negedge clk);
        dmem_valid = 1'b1;
        dmem_addr  = a;
        dmem_wdata = d;
        dmem_wen   = w;
        n0 = acc_cnt;
        k  = 0;
        do begin
            @(negedge clk);
            k++;
        end while (acc_cnt == n0 && k < 20);
        if (acc_cnt == n0) begin
            dmem_valid = 1'b0;
            fail_timeout("accept");
            return;
        end
        k = 0;
        // Garbage on the inputs while busy must not disturb the captured request.
        while (!dmem_resp_valid && k < 20) begin
            dmem_valid = 1'($urandom_range(0, 1));
            dmem_addr  = $urandom;
            dmem_wdata = $urandom;
            dmem_wen   = 4'($urandom);
            @(negedge clk);
            k++;
        end
        dmem_valid = 1'b0;
        if (!dmem_resp_valid) begin
            fail_timeout("response");
            return;
        end
        rd  = dmem_rdata;
        er  = dmem_err;
        lat = cyc - acc_cyc;
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        int idx;
        r = $urandom_range(0, 9);
        if (r == 0) return BASE - 32'(4 * $urandom_range(1, 4));
        if (r == 1) return BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 3));
        idx = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 15) : (DEPTH - 4 + $urandom_range(0, 3));
        return BASE + 32'(4 * idx) + 32'($urandom_range(0, 3));
    endfunction

    function automatic logic [3:0] rand_wen();
        logic [3:0] lw [7];
        int r;
        lw = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
        r = $urandom_range(0, 9);
        if (r < 5) return 4'b0000;
        if (r < 9) return lw[$urandom_range(0, 6)];
        return 4'($urandom);
    endfunction

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          n0;
        int          k;

        rst        = 1'b0;
        dmem_valid = 1'b0;
        dmem_addr  = 32'h0;
        dmem_wdata = 32'h0;
        dmem_wen   = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", dmem_ready, 32'h0);
        chk("reset_resp_valid", dmem_resp_valid, 32'h0);
        chk("reset_err", dmem_err, 32'h0);
        chk("reset_rdata", dmem_rdata, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;
        chk("ready_after_release", dmem_ready, 32'h1);

        for (int i = 0; i < 16; i++) do_req(BASE + 32'(4 * i), $urandom, 4'b1111, rd, er, lat);
        for (int i = 0; i < 4; i++) do_req(BASE + 32'(4 * (DEPTH - 4 + i)), $urandom, 4'b1111, rd, er, lat);

        do_req(32'h8000_0004, 32'hDEAD_BEEF, 4'b1111, rd, er, lat);
        chk("word_write_latency", 32'(lat), 32'd2);
        chk("word_write_err", er, 32'h0);
        do_req(32'h8000_0004, 32'h0, 4'b0000, rd, er, lat);
        chk("word_read_latency", 32'(lat), 32'd2);
        chk("word_read_err", er, 32'h0);
        chk("word_read_data", rd, 32'hDEAD_BEEF);

        do_req(32'h8000_0006, 32'h0000_0055, 4'b0100, rd, er, lat);
        do_req(32'h8000_0004, 32'h0, 4'b0000, rd, er, lat);
        chk("byte_store_data", rd, 32'hDE55_BEEF);

        do_req(32'h8000_0004, 32'hDEAD_BEEF, 4'b1111, rd, er, lat);
        do_req(32'h8000_0006, 32'h0000_1234, 4'b1100, rd, er, lat);
        do_req(32'h8000_0004, 32'h0, 4'b0000, rd, er, lat);
        chk("half_store_data", rd, 32'h1234_BEEF);

        do_req(32'h8000_0000, 32'h0BAD_F00D, 4'b1111, rd, er, lat);
        do_req(32'h7FFF_FFFC, 32'h0, 4'b0000, rd, er, lat);
        chk("below_base_err", er, 32'h1);
        chk("below_base_rdata", rd, 32'h0);
        do_req(32'h8000_1000, 32'hFFFF_FFFF, 4'b1111, rd, er, lat);
        chk("above_top_err", er, 32'h1);
        do_req(32'h8000_0000, 32'h0, 4'b0000, rd, er, lat);
        chk("oor_no_alias_write", rd, 32'h0BAD_F00D);

        do_req(32'h8000_0004, 32'hFFFF_FFFF, 4'b0110, rd, er, lat);
        chk("wen_0110_err", er, 32'h1);
        do_req(32'h8000_0004, 32'hFFFF_FFFF, 4'b0101, rd, er, lat);
        chk("wen_0101_err", er, 32'h1);
        do_req(32'h8000_0004, 32'h0, 4'b0000, rd, er, lat);
        chk("illegal_wen_no_write", rd, 32'h1234_BEEF);

        // Reset lands on the edge that would commit a store.
        @(negedge clk);
        dmem_valid = 1'b1;
        dmem_addr  = 32'h8000_0004;
        dmem_wdata = 32'hCAFE_F00D;
        dmem_wen   = 4'b1111;
        n0 = acc_cnt;
        k  = 0;
        do begin
            @(negedge clk);
            k++;
        end while (acc_cnt == n0 && k < 20);
        dmem_valid = 1'b0;
        if (acc_cnt == n0) begin
            fail_timeout("reset_test_accept");
        end else begin
            k = 0;
            while (cyc < acc_cyc + LAT && k < 20) begin
                @(negedge clk);
                k++;
            end
            chk("reset_test_in_resp", dmem_resp_valid, 32'h1);
            rst = 1'b0;
            repeat (2) @(negedge clk);
            chk("reset_test_no_strobe", dmem_resp_valid, 32'h0);
            rst = 1'b1;
            @(negedge clk);
            chk("reset_test_ready", dmem_ready, 32'h1);
        end
        do_req(32'h8000_0004, 32'h0, 4'b0000, rd, er, lat);
        chk("reset_aborts_write", rd, 32'h1234_BEEF);

        for (int i = 0; i < 400; i++) begin
            do_req(rand_addr(), $urandom, rand_wen(), rd, er, lat);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_resp.md
DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, storage depth in 32-bit words (power of two).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h8000_0000, byte address of word 0.
REQ-003 SHALL have parameter LATENCY, default 2, legal range 1..7, cycles from accept to response.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-low (rst=0 resets on the next rising clk).
REQ-006 SHALL have port dmem_valid  input  1  request present.
REQ-007 SHALL have port dmem_addr  input  32  byte address.
REQ-008 SHALL have port dmem_wdata  input  32  store data, unshifted (byte in [7:0], half in [15:0], word in [31:0]).
REQ-009 SHALL have port dmem_wen  input  4  byte strobes, lane-positioned; 4'b0000 means read.
REQ-010 SHALL have port dmem_ready  output  1  request can be accepted this cycle.
REQ-011 SHALL have port dmem_resp_valid  output  1  one-cycle response strobe.
REQ-012 SHALL have port dmem_rdata  output  32  aligned word at the addressed word; lane extraction is done by the requester.
REQ-013 SHALL have port dmem_err  output  1  response is an error; valid only with dmem_resp_valid.

Function
REQ-014 SHALL use FSM states IDLE, WAIT, RESP, with one outstanding request at most.
REQ-015 SHALL assert dmem_ready only in IDLE; accept occurs on a rising edge where dmem_valid=1 and dmem_ready=1.
REQ-016 SHALL on accept capture addr, wdata and wen into internal registers; inputs are ignored afterwards until the next IDLE.
REQ-017 SHALL with acceptance in cycle c assert dmem_resp_valid for exactly cycle c+LATENCY, then return to IDLE in cycle c+LATENCY+1.
REQ-018 SHALL for LATENCY=1 transition IDLE->RESP directly; for LATENCY>1 go IDLE->WAIT, load down-counter LATENCY-2, WAIT->RESP when the counter is 0.
REQ-019 SHALL compute word index = (addr - BASE_ADDR) >> 2 and flag out-of-range if addr < BASE_ADDR or index >= DEPTH_WORDS.
REQ-020 SHALL treat legal wen as 0000, 0001, 0010, 0100, 1000, 0011, 1100, 1111; any other pattern is an error.
REQ-021 SHALL align store data to lanes: single-byte strobe replicates wdata[7:0] to the strobed lane, half strobe places wdata[15:0] in the strobed half, 1111 writes wdata unchanged.
REQ-022 SHALL commit a write on the rising edge that ends the RESP cycle, only unstrobed-lane-preserving, and only when not in error.
REQ-023 SHALL on a read drive dmem_rdata with the stored word during the RESP cycle; dmem_rdata is 0 outside RESP and on error.
REQ-024 SHALL on error (out-of-range or illegal wen) assert dmem_err with dmem_resp_valid, perform no write, and return rdata 0.
REQ-025 SHALL for a read accepted after a write's commit edge return the newly written data (no stale reads).
REQ-026 SHALL hold dmem_resp_valid and dmem_err at 0 in IDLE and WAIT.
REQ-027 SHALL tolerate dmem_valid dropping after accept; the response is still produced.

Reset
REQ-028 SHALL on a rising edge with rst=0 force IDLE, counter 0, dmem_resp_valid=0, dmem_err=0, dmem_rdata=0; reset has priority over every other event.
REQ-029 SHALL drive dmem_ready=0 while rst=0 and set it to 1 in the first cycle after reset is released.
REQ-030 SHALL abort an in-flight request on reset with no write committed, even if reset coincides with the RESP-ending edge.
REQ-031 SHALL NOT clear storage contents on reset.

Verification
REQ-032 SHALL cover: LATENCY=2, write addr 0x8000_0004 wen 1111 wdata 0xDEADBEEF, then read 0x8000_0004 -> resp_valid exactly 2 cycles after each accept, rdata 0xDEADBEEF, err 0.
REQ-033 SHALL cover: word 0xDEADBEEF at 0x8000_0004, byte store addr 0x8000_0006 wen 0100 wdata 0x0000_0055, then read -> rdata 0xDE55BEEF.
REQ-034 SHALL cover: half store addr 0x8000_0006 wen 1100 wdata 0x0000_1234 over 0xDEADBEEF -> read rdata 0x1234BEEF.
REQ-035 SHALL cover: read addr 0x7FFF_FFFC and write addr BASE+4*DEPTH_WORDS -> err=1, rdata 0, later read shows memory unchanged.
REQ-036 SHALL cover: illegal wen 0110 -> err=1, no write; wen 0101 -> err=1.
REQ-037 SHALL cover: rst=0 in the RESP cycle of a write 0xCAFEF00D -> no resp strobe after reset, ready=1 after release, read returns prior value.
